// File: rtl/multicore_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicore_pkg
// Description : Shared cache/memory geometry plus the types used by the
//               block-fill responder (line, index, buffered beat, FSM state).
// Revision    : 1.0 - initial release
// ============================================================================
package multicore_pkg;

  localparam int LINES_PER_BLK = 256;
  localparam int LINE_SIZE     = 32;
  localparam int OFFSET        = 2;
  localparam int BLOCK_SIZE    = 1024;

  localparam int IDX_W         = $clog2(LINES_PER_BLK);
  localparam int BLK_OFFSET    = $clog2(BLOCK_SIZE);

  typedef logic [LINE_SIZE-1:0] line_t;
  typedef logic [IDX_W-1:0]     idx_t;

  // One response beat as held in the output buffer.
  typedef struct packed {
    line_t data;
    idx_t  idx;
    logic  last;
  } beat_t;

  typedef enum logic [1:0] {
    FILL_IDLE   = 2'd0,
    FILL_STREAM = 2'd1,
    FILL_DRAIN  = 2'd2
  } fill_state_e;

endpackage
`default_nettype wire

// File: rtl/cache_fill_responder_fill_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fill_skid_buf
// Description : Two-entry FIFO of response beats. Absorbs the RAM read
//               latency so the response channel can stall without losing
//               data. Flush empties it in one edge.
// Revision    : 1.0 - initial release
// ============================================================================
module fill_skid_buf
  import multicore_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  input  logic       flush,
  output beat_t      head_beat,
  output logic [1:0] count
);

  beat_t      ent_q [2];
  beat_t      ent_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       pop_ok;
  logic       push_ok;

  // Next-state: a pop frees a slot in the same edge, so push into a full
  // buffer is legal when it coincides with a pop.
  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop && (count_q != 2'd0);
    push_ok  = push && ((count_q != 2'd2) || pop_ok);
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) begin
        ent_d[wr_ptr_q] = push_beat;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // Storage and pointers; entries clear on reset so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      ent_q    <= ent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_beat = ent_q[rd_ptr_q];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/cache_fill_responder.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_responder
// Description : Accepts one block-fill request, reads the 256 lines of the
//               block from a 1-cycle-latency word RAM and streams them out
//               in index order over a valid/ready channel. Abort flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_responder
  import multicore_pkg::*;
#(
  parameter int MEM_WORDS  = 16384,
  parameter int MEM_ADDR_W = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  abort,
  output logic                  mem_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [LINE_SIZE-1:0]  mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [LINE_SIZE-1:0]  rsp_data,
  output logic [IDX_W-1:0]      rsp_idx,
  output logic                  rsp_last
);

  localparam int   BASE_W   = 32 - BLK_OFFSET;
  localparam idx_t LAST_IDX = IDX_W'(LINES_PER_BLK - 1);

  fill_state_e         state_q, state_d;
  idx_t                issue_cnt_q, issue_cnt_d;
  logic [BASE_W-1:0]   blk_base_q, blk_base_d;
  logic                inflight_q, inflight_d;
  idx_t                inflight_idx_q, inflight_idx_d;

  logic [1:0]          buf_count;
  beat_t               head_beat;
  beat_t               push_beat;
  logic                accept;
  logic                rsp_fire;
  logic                issue;
  logic [BASE_W+IDX_W-1:0] word_addr;

  // Handshakes, read issue and next state. Issue counts the beat leaving
  // this edge as already gone so the stream sustains one beat per cycle
  // while never holding more than two reads buffered or in flight.
  always_comb begin
    state_d        = state_q;
    issue_cnt_d    = issue_cnt_q;
    blk_base_d     = blk_base_q;
    rsp_valid      = (buf_count != 2'd0);
    rsp_fire       = rsp_valid && rsp_ready;
    req_ready      = (state_q == FILL_IDLE);
    accept         = req_valid && req_ready && !abort;
    issue          = (state_q == FILL_STREAM) && !abort &&
                     (({1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, rsp_fire}) < 3'd2);
    inflight_d     = issue;
    inflight_idx_d = issue ? issue_cnt_q : inflight_idx_q;
    if (abort) begin
      state_d = FILL_IDLE;
    end else begin
      case (state_q)
        FILL_IDLE: begin
          if (accept) begin
            state_d     = FILL_STREAM;
            issue_cnt_d = '0;
            blk_base_d  = BASE_W'(req_addr >> BLK_OFFSET);
          end
        end
        FILL_STREAM: begin
          if (issue) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
            if (issue_cnt_q == LAST_IDX) begin
              state_d = FILL_DRAIN;
            end
          end
        end
        FILL_DRAIN: begin
          if (rsp_fire && head_beat.last) begin
            state_d = FILL_IDLE;
          end
        end
        default: state_d = FILL_IDLE;
      endcase
    end
  end

  // RAM address is the block-aligned line address wrapped to the RAM depth.
  always_comb begin
    word_addr      = {blk_base_q, issue_cnt_q};
    mem_en         = issue;
    mem_addr       = MEM_ADDR_W'(word_addr);
    push_beat.data = mem_rdata;
    push_beat.idx  = inflight_idx_q;
    push_beat.last = (inflight_idx_q == LAST_IDX);
    rsp_data       = head_beat.data;
    rsp_idx        = head_beat.idx;
    rsp_last       = head_beat.last;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FILL_IDLE;
      issue_cnt_q    <= '0;
      blk_base_q     <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
    end else begin
      state_q        <= state_d;
      issue_cnt_q    <= issue_cnt_d;
      blk_base_q     <= blk_base_d;
      inflight_q     <= inflight_d;
      inflight_idx_q <= inflight_idx_d;
    end
  end

  fill_skid_buf u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_beat (push_beat),
    .pop       (rsp_fire),
    .flush     (abort),
    .head_beat (head_beat),
    .count     (buf_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_fill_responder
// Description : Directed sequence of block fills with randomized response
//               back-pressure, compared against a queue-based model of the
//               expected beat stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_responder;
  import multicore_pkg::*;

  localparam int MEM_WORDS  = 16384;
  localparam int MEM_ADDR_W = $clog2(MEM_WORDS);

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic [31:0]           req_addr = '0;
  logic                  abort = 1'b0;
  logic                  mem_en;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [LINE_SIZE-1:0]  mem_rdata;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [LINE_SIZE-1:0]  rsp_data;
  logic [IDX_W-1:0]      rsp_idx;
  logic                  rsp_last;

  logic [31:0] mem [MEM_WORDS];

  cache_fill_responder #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .abort     (abort),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_idx   (rsp_idx),
    .rsp_last  (rsp_last)
  );

  always #5 clk = ~clk;

  // Backing RAM: synchronous read, one cycle latency.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  int    passed = 0;
  int    total  = 0;
  int    cyc    = 0;
  int    issued = 0;
  int    hs     = 0;
  int    first_hs = 0;
  int    last_hs  = 0;
  int    mode   = 0;   // 0: ready=1, 1: ready 1-in-3, 2: random, other: hold
  bit    accepted = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;
  beat_t exp_q[$];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Line idx of the block holding addr, located in a RAM of MEM_WORDS lines.
  function automatic logic [31:0] exp_word(logic [31:0] addr, int idx);
    int unsigned w;
    w = ((addr / 1024) * 256 + idx) % MEM_WORDS;
    return 32'hA500_0000 | w;
  endfunction

  // One clock: observe mid-cycle before the edge, update the model, advance.
  task automatic tick();
    beat_t cur;
    beat_t e;
    beat_t nb;
    @(negedge clk);
    cur.data = rsp_data;
    cur.idx  = rsp_idx;
    cur.last = rsp_last;
    accepted = 1'b0;
    if (prev_stall && !rst)
      check("stall_hold", 64'({rsp_valid, cur}), 64'({1'b1, prev_beat}));
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else if (abort) begin
      exp_q.delete();
      prev_stall = 1'b0;
      issued = 0;
      hs = 0;
    end else begin
      if (req_valid && req_ready) begin
        accepted = 1'b1;
        issued = 0;
        hs = 0;
        for (int i = 0; i < 256; i++) begin
          nb.data = exp_word(req_addr, i);
          nb.idx  = 8'(i);
          nb.last = (i == 255);
          exp_q.push_back(nb);
        end
      end
      if (rsp_valid && rsp_ready) begin
        hs++;
        if (hs == 1) first_hs = cyc;
        last_hs = cyc;
        if (exp_q.size() == 0) begin
          check("no_extra_beat", 64'(rsp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'(cur), 64'(e));
        end
      end
      if (mem_en) issued++;
      if (mem_en || rsp_valid)
        check("outstanding_le2", 64'(issued - hs <= 2), 64'd1);
      prev_stall = rsp_valid && !rsp_ready;
      prev_beat  = cur;
    end
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = (cyc % 3 == 0);
      2: rsp_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  // Present a request, wait for acceptance, then check start-up latency.
  task automatic start_fill(logic [31:0] addr);
    int n;
    n = 0;
    req_addr  = addr;
    req_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!accepted && n < 20);
    check("accepted", 64'(accepted), 64'd1);
    req_valid = 1'b0;
    check("req_ready_busy", 64'(req_ready), 64'd0);
    check("mem_en_first", 64'(mem_en), 64'd1);
    check("mem_addr_first", 64'(mem_addr), 64'(((addr / 1024) * 256) % MEM_WORDS));
    check("rsp_valid_e0", 64'(rsp_valid), 64'd0);
    tick();
    check("rsp_valid_e1", 64'(rsp_valid), 64'd0);
    tick();
    check("rsp_valid_e2", 64'(rsp_valid), 64'd1);
    check("first_idx", 64'(rsp_idx), 64'd0);
  endtask

  // Run until the model has seen every expected beat.
  task automatic finish_fill();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    check("fill_complete", 64'(exp_q.size()), 64'd0);
    check("req_ready_after", 64'(req_ready), 64'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hA500_0000 | 32'(i);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(rsp_data),  64'd0);
    check("rst_rsp_idx",   64'(rsp_idx),   64'd0);
    check("rst_rsp_last",  64'(rsp_last),  64'd0);
    check("rst_mem_en",    64'(mem_en),    64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;

    // Full-rate fill; 256 consecutive handshakes.
    mode = 0; rsp_ready = 1'b1;
    start_fill(32'h0000_0400);
    finish_fill();
    check("burst_span", 64'(last_hs - first_hs), 64'd255);

    // Unaligned address inside the same block.
    start_fill(32'h0000_07FC);
    finish_fill();
    check("burst_span_unaligned", 64'(last_hs - first_hs), 64'd255);

    // Ready one cycle in three.
    mode = 1;
    start_fill(32'h0000_0400);
    finish_fill();

    // Random back-pressure.
    mode = 2;
    start_fill(32'h0000_0C00);
    finish_fill();

    // Abort while beat 100 is stalled.
    mode = 9; rsp_ready = 1'b1;
    start_fill(32'h0000_0400);
    n = 0;
    while (!(rsp_valid && rsp_idx == 8'd100) && n < 500) begin
      tick();
      n++;
    end
    check("reached_idx100", 64'(rsp_idx), 64'd100);
    rsp_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_mem_en",    64'(mem_en),    64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    mode = 0; rsp_ready = 1'b1;
    start_fill(32'h0000_0800);
    finish_fill();

    // Abort together with a request in IDLE: request must be refused.
    req_valid = 1'b1; req_addr = 32'h0000_0400; abort = 1'b1;
    tick();
    abort = 1'b0; req_valid = 1'b0;
    check("abort_beats_req", 64'(req_ready), 64'd1);

    // Asynchronous reset mid-burst.
    start_fill(32'h0000_0400);
    repeat (50) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_mem_en",    64'(mem_en),    64'd0);
    check("arst_rsp_idx",   64'(rsp_idx),   64'd0);
    check("arst_rsp_data",  64'(rsp_data),  64'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("arst_req_ready", 64'(req_ready), 64'd1);
    start_fill(32'h0000_0400);
    finish_fill();

    // Address wrap plus a request held high across the end of the fill.
    start_fill(32'h0001_0400);
    req_addr  = 32'h0000_0800;
    req_valid = 1'b1;
    finish_fill();
    tick();
    check("b2b_accept", 64'(accepted), 64'd1);
    req_valid = 1'b0;
    finish_fill();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
